// File: rtl/imem_pkg.sv
// Shared error codes, the default instruction word and the fault-priority helper
// for the instruction fetch memory.
package imem_pkg;

    typedef enum logic [1:0] {
        IMEM_OK       = 2'd0,
        IMEM_MISALIGN = 2'd1,
        IMEM_OOR      = 2'd2,
        IMEM_PARITY   = 2'd3
    } imem_err_e;

    localparam logic [31:0] IMEM_DEFAULT_INSTR = 32'hDEADBEEF;

    // Misalignment outranks out-of-range; parity is resolved after the array read.
    function automatic imem_err_e imem_decode_err(input logic misalign, input logic oor);
        if (misalign) begin
            return IMEM_MISALIGN;
        end
        if (oor) begin
            return IMEM_OOR;
        end
        return IMEM_OK;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry response buffer; push and pop may coincide at any occupancy,
// including full, leaving the count unchanged.
module imem_rsp_fifo #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_slot [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_count   = r_count;
    assign o_data    = r_slot[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // When full, the write slot is the head being popped on the same edge.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_slot[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: word array, fault decode, one-cycle read stage and a
// 2-entry response buffer. Define IMEM_PARITY_EN to add a per-word even-parity bit.
module instr_fetch_mem
    import imem_pkg::*;
#(
    parameter int                DATA_W        = 32,
    parameter int                DEPTH         = 1024,
    parameter logic [DATA_W-1:0] DEFAULT_INSTR = DATA_W'(IMEM_DEFAULT_INSTR)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_pc,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_instr,
    output logic [1:0]               rsp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = DATA_W + 2;

    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: DEFAULT_INSTR};
`ifdef IMEM_PARITY_EN
    logic              r_par [DEPTH] = '{default: ^DEFAULT_INSTR};
    logic              r_rpar_p1;
`endif

    logic [AW-1:0]     w_idx;
    logic              w_misalign;
    logic              w_oor;
    logic              w_accept;
    logic              r_run;
    logic              r_vld_p1;
    imem_err_e         r_err_p1;
    logic [DATA_W-1:0] r_rdata_p1;
    imem_err_e         w_err_p1;
    logic [DATA_W-1:0] w_instr_p1;
    logic [FW-1:0]     w_fifo_din;
    logic [FW-1:0]     w_fifo_dout;
    logic [FW-1:0]     w_out_word;
    logic              w_fifo_empty;
    logic [1:0]        w_fifo_count;
    logic              w_push;
    logic              w_pop;

    assign w_idx      = req_pc[AW+1:2];
    assign w_misalign = |req_pc[1:0];
    assign w_oor      = ({2'b00, req_pc[31:2]} >= 32'(DEPTH));
    assign req_ready  = r_run &&
                        (({1'b0, w_fifo_count} + {2'b00, r_vld_p1}) < 3'd2);
    assign w_accept   = req_valid && req_ready;

    // Stage p0 -> p1: accept, classify, read the array
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run    <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_err_p1 <= IMEM_OK;
        end else begin
            r_run    <= 1'b1;
            r_vld_p1 <= w_accept;
            if (w_accept) begin
                r_err_p1 <= imem_decode_err(w_misalign, w_oor);
            end
        end
    end

    // Faulting fetches never touch the array; a same-cycle load lands after the read.
    always_ff @(posedge clk) begin
        if (w_accept && !w_misalign && !w_oor) begin
            r_rdata_p1 <= r_mem[w_idx];
`ifdef IMEM_PARITY_EN
            r_rpar_p1  <= r_par[w_idx];
`endif
        end
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
`ifdef IMEM_PARITY_EN
            r_par[ld_addr] <= ^ld_data;
`endif
        end
    end

    always_comb begin
        w_err_p1   = r_err_p1;
        w_instr_p1 = r_rdata_p1;
`ifdef IMEM_PARITY_EN
        if ((r_err_p1 == IMEM_OK) && ((^r_rdata_p1) != r_rpar_p1)) begin
            w_err_p1 = IMEM_PARITY;
        end
`endif
        if (w_err_p1 != IMEM_OK) begin
            w_instr_p1 = DEFAULT_INSTR;
        end
    end

    // Stage p1 -> output: bypass when the buffer is empty, otherwise queue behind it
    assign w_fifo_din = {w_err_p1, w_instr_p1};
    assign w_push     = r_vld_p1 && !(w_fifo_empty && rsp_ready);
    assign w_pop      = !w_fifo_empty && rsp_ready;

    imem_rsp_fifo #(
        .WIDTH (FW)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_fifo_din),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign rsp_valid  = w_fifo_empty ? r_vld_p1 : 1'b1;
    assign w_out_word = w_fifo_empty ? w_fifo_din : w_fifo_dout;
    assign rsp_instr  = rsp_valid ? w_out_word[DATA_W-1:0] : '0;
    assign rsp_err    = rsp_valid ? w_out_word[FW-1:DATA_W] : 2'b00;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: expected responses are queued when a request is
// accepted and compared in order when the response handshake completes.
module tb_instr_fetch_mem;

    localparam int          DEPTH = 1024;
    localparam int          AW    = 10;
    localparam logic [31:0] DEF   = 32'hDEADBEEF;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_pc    = 32'd0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_instr;
    logic [1:0]    rsp_err;
    logic          ld_en     = 1'b0;
    logic [AW-1:0] ld_addr   = '0;
    logic [31:0]   ld_data   = 32'd0;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [33:0]   sb_q[$];
    logic [31:0]   model_mem [DEPTH];
    bit            par_bad   [DEPTH];
    bit            stall_prev = 1'b0;
    logic [31:0]   stall_instr;
    logic [1:0]    stall_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    instr_fetch_mem #(
        .DATA_W        (32),
        .DEPTH         (DEPTH),
        .DEFAULT_INSTR (DEF)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    function automatic logic [33:0] expect_fetch(input logic [31:0] pc);
        logic [AW-1:0] idx;
        idx = pc[AW+1:2];
        if (pc[1:0] != 2'b00) return {2'd1, DEF};
        if (pc[31:2] >= 30'(DEPTH)) return {2'd2, DEF};
        if (par_bad[idx]) return {2'd3, DEF};
        return {2'd0, model_mem[idx]};
    endfunction

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        logic [33:0] exp_v;
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_instr !== stall_instr || rsp_err !== stall_err) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b instr=%h err=%0d, required valid=1 instr=%h err=%0d",
                             rsp_valid, rsp_instr, rsp_err, stall_instr, stall_err);
                end
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: instr=%h err=%0d, required no response", rsp_instr, rsp_err);
                end else begin
                    exp_v = sb_q.pop_front();
                    if ({rsp_err, rsp_instr} !== exp_v) begin
                        errors++;
                        $display("FAIL sb_response: instr=%h err=%0d, required instr=%h err=%0d",
                                 rsp_instr, rsp_err, exp_v[31:0], exp_v[33:32]);
                    end
                end
            end
            stall_prev  = (rsp_valid === 1'b1) && (rsp_ready !== 1'b1);
            stall_instr = rsp_instr;
            stall_err   = rsp_err;
            if (req_valid && req_ready === 1'b1) sb_q.push_back(expect_fetch(req_pc));
            if (ld_en) begin
                model_mem[ld_addr] = ld_data;
                par_bad[ld_addr]   = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = AW'(a);
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    // Leaves req_valid high so consecutive calls form back-to-back requests.
    task automatic issue(input logic [31:0] pc);
        bit took;
        took      = 1'b0;
        req_valid = 1'b1;
        req_pc    = pc;
        for (int n = 0; n < 32 && !took; n++) begin
            @(negedge clk);
            took = (req_ready === 1'b1);
            tick();
        end
        checks++;
        if (!took) begin
            errors++;
            $display("FAIL issue_accept: pc=%h not accepted, required accept within 32 cycles", pc);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 64 && sb_q.size() != 0; n++) tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d responses outstanding, required 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_instr !== 32'd0 || rsp_err !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b ready=%b instr=%h err=%0d, required all 0",
                     rsp_valid, req_ready, rsp_instr, rsp_err);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: req_ready=%b, required 0", req_ready);
        end
        tick();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_edge: req_ready=%b rsp_valid=%b, required 1 and 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [4];
        int          c0;
        for (int i = 0; i < 4; i++) begin
            exp_w[i] = 32'(32'h11111111 * (i + 1));
            load_word(i, exp_w[i]);
        end
        rsp_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            issue(32'(i * 4));
            checks++;
            if (rsp_valid !== 1'b1 || rsp_instr !== exp_w[i] || rsp_err !== 2'd0) begin
                errors++;
                $display("FAIL b2b_latency: valid=%b instr=%h err=%0d, required valid=1 instr=%h err=0",
                         rsp_valid, rsp_instr, rsp_err, exp_w[i]);
            end
        end
        checks++;
        if (cyc - c0 != 4) begin
            errors++;
            $display("FAIL b2b_rate: %0d cycles for 4 fetches, required 4", cyc - c0);
        end
        req_valid = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_trailing: rsp_valid=%b, required 0", rsp_valid);
        end
        drain("b2b");
    endtask

    task automatic test_faults();
        logic [31:0] pcs  [5];
        logic [1:0]  errs [5];
        pcs[0] = 32'h0000_0006; errs[0] = 2'd1;
        pcs[1] = 32'h0000_1000; errs[1] = 2'd2;
        pcs[2] = 32'h0000_1002; errs[2] = 2'd1;
        pcs[3] = 32'h0000_0FFC; errs[3] = 2'd0;
        pcs[4] = 32'hFFFF_FFFE; errs[4] = 2'd1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(pcs[i]);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_instr !== DEF || rsp_err !== errs[i]) begin
                errors++;
                $display("FAIL fault_pc_%h: valid=%b instr=%h err=%0d, required valid=1 instr=%h err=%0d",
                         pcs[i], rsp_valid, rsp_instr, rsp_err, DEF, errs[i]);
            end
        end
        req_valid = 1'b0;
        drain("faults");
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        issue(32'h0);
        issue(32'h4);
        req_valid = 1'b1;
        req_pc    = 32'h8;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_drop: req_ready=%b after 2 accepts, required 0", req_ready);
        end
        tick();
        tick();
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_instr !== 32'h11111111) begin
            errors++;
            $display("FAIL bp_head: ready=%b valid=%b instr=%h, required ready=0 valid=1 instr=11111111",
                     req_ready, rsp_valid, rsp_instr);
        end
        rsp_ready = 1'b1;
        issue(32'h8);
        req_valid = 1'b0;
        drain("bp");
    endtask

    task automatic test_rbw();
        rsp_ready = 1'b1;
        load_word(8, 32'h0BADF00D);
        ld_en   = 1'b1;
        ld_addr = AW'(8);
        ld_data = 32'hAAAA5555;
        issue(32'h20);
        ld_en = 1'b0;
        checks++;
        if (rsp_instr !== 32'h0BADF00D || rsp_err !== 2'd0) begin
            errors++;
            $display("FAIL rbw_old: instr=%h err=%0d, required 0badf00d err=0", rsp_instr, rsp_err);
        end
        issue(32'h20);
        req_valid = 1'b0;
        checks++;
        if (rsp_instr !== 32'hAAAA5555 || rsp_err !== 2'd0) begin
            errors++;
            $display("FAIL rbw_new: instr=%h err=%0d, required aaaa5555 err=0", rsp_instr, rsp_err);
        end
        drain("rbw");
    endtask

    task automatic test_random_ready();
        bit          stop;
        logic [31:0] pc;
        int unsigned sel;
        stop = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    sel = $urandom_range(0, 9);
                    pc  = 32'($urandom_range(0, 15)) << 2;
                    if (sel == 0) pc = pc | 32'h1;
                    if (sel == 1) pc = pc | 32'h0000_4000;
                    issue(pc);
                    if ($urandom_range(0, 3) == 0) begin
                        req_valid = 1'b0;
                        tick();
                    end
                end
                req_valid = 1'b0;
                stop      = 1'b1;
            end
            begin
                while (!stop) begin
                    rsp_ready = ($urandom_range(0, 2) != 0);
                    tick();
                end
            end
        join
        rsp_ready = 1'b1;
        drain("random");
    endtask

    task automatic test_reset_midop();
        rsp_ready = 1'b0;
        issue(32'h0);
        issue(32'h4);
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_instr !== 32'd0 || rsp_err !== 2'd0) begin
            errors++;
            $display("FAIL midop_reset: valid=%b ready=%b instr=%h err=%0d, required all 0",
                     rsp_valid, req_ready, rsp_instr, rsp_err);
        end
        sb_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midop_ready_early: req_ready=%b, required 0", req_ready);
        end
        tick();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_ready_edge: req_ready=%b rsp_valid=%b, required 1 and 0", req_ready, rsp_valid);
        end
        rsp_ready = 1'b1;
        issue(32'h0);
        issue(32'h4);
        req_valid = 1'b0;
        checks++;
        if (rsp_instr !== 32'h22222222 || rsp_err !== 2'd0) begin
            errors++;
            $display("FAIL midop_preserved: instr=%h err=%0d, required 22222222 err=0", rsp_instr, rsp_err);
        end
        drain("midop");
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        rsp_ready = 1'b1;
        load_word(5, 32'h55555555);
        dut.r_par[5] = !dut.r_par[5];
        par_bad[5]   = 1'b1;
        issue(32'h14);
        req_valid = 1'b0;
        checks++;
        if (rsp_instr !== DEF || rsp_err !== 2'd3) begin
            errors++;
            $display("FAIL parity_flip: instr=%h err=%0d, required deadbeef err=3", rsp_instr, rsp_err);
        end
        drain("parity");
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = DEF;
            par_bad[i]   = 1'b0;
        end
        test_reset();
        test_back_to_back();
        test_faults();
        test_backpressure();
        test_rbw();
        test_random_ready();
        test_reset_midop();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected responses unseen, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter DATA_W, default 32, instruction width in bits.
REQ-002 Parameter DEPTH, default 1024, number of instruction words; power of two, at least 4.
REQ-003 Parameter DEFAULT_INSTR, default 32'hDEADBEEF, returned for faulting fetches.
REQ-004 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 Port reset_n, input, 1; reset is asynchronous and active-low.
REQ-006 Port req_valid / req_ready, input / output, 1 each, fetch request handshake.
REQ-007 Port req_pc, input, 32, byte address of the fetch.
REQ-008 Port rsp_valid / rsp_ready, output / input, 1 each, response handshake.
REQ-009 Port rsp_instr, output, DATA_W, fetched instruction.
REQ-010 Port rsp_err, output, 2, error code: 0 OK, 1 misaligned, 2 out-of-range, 3 parity.
REQ-011 Port ld_en / ld_addr / ld_data, input, 1 / $clog2(DEPTH) / DATA_W, word-indexed program-load write port.

Function
REQ-012 The request is accepted on a cycle where req_valid && req_ready; the word index is req_pc[31:2].
REQ-013 Latency: the accepted request's response is presented on rsp_valid exactly 1 cycle later if the response buffer is empty and rsp_ready is high.
REQ-014 The response buffer is a 2-entry FIFO; req_ready = (FIFO occupancy + in-flight reads) < 2.
REQ-015 Responses are returned strictly in request order; none are dropped or duplicated under any rsp_ready pattern.
REQ-016 req_pc[1:0] != 0: rsp_instr = DEFAULT_INSTR, rsp_err = 1; the array is not read.
REQ-017 req_pc[31:2] >= DEPTH, aligned: rsp_instr = DEFAULT_INSTR, rsp_err = 2.
REQ-018 Misalignment takes priority over out-of-range.
REQ-019 ld_en writes ld_data to ld_addr at the clock edge, independent of the fetch handshake.
REQ-020 A fetch and a load to the same word in the same cycle: the fetch returns the old contents (read-before-write).
REQ-021 rsp_valid stays high and rsp_instr/rsp_err stay stable until rsp_ready is sampled high.
REQ-022 A simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.

Reset
REQ-023 While reset_n is low: rsp_valid = 0, req_ready = 0, rsp_instr = 0, rsp_err = 0, FIFO empty, in-flight reads discarded.
REQ-024 req_ready rises on the first clock edge after reset_n deasserts.
REQ-025 Array contents are not cleared by reset; a reset in mid-operation loses only pending responses.
REQ-026 Simulation initial contents: every word = DEFAULT_INSTR.

Configuration
REQ-027 Macro IMEM_PARITY_EN: when defined, each word stores an even-parity bit computed on load, and a mismatch on fetch yields rsp_err = 3 with rsp_instr = DEFAULT_INSTR.
REQ-028 Without IMEM_PARITY_EN: no parity storage, and rsp_err never equals 3.

Structure
REQ-029 Package imem_pkg holds the rsp_err enum (IMEM_OK, IMEM_MISALIGN, IMEM_OOR, IMEM_PARITY) and the DEFAULT_INSTR constant.
REQ-030 Sub-module imem_rsp_fifo (2-entry, parametrised width) implements the response buffer; the array and fault decode live in instr_fetch_mem.

Verification
REQ-031 Load words 0..3 with 0x11111111..0x44444444, then issue back-to-back fetches to pc 0,4,8,12 with rsp_ready=1 -> responses appear one per cycle starting 1 cycle after the first accept, in order, with err 0.
REQ-032 Fetch pc 0x6 -> DEADBEEF, err 1; fetch pc 0x1000 (DEPTH 1024) -> DEADBEEF, err 2; fetch pc 0x1002 -> err 1.
REQ-033 Hold rsp_ready=0 while issuing 3 requests -> req_ready drops after 2 accepts; release -> all 3 responses return in order.
REQ-034 Fetch pc 0x20 while loading ld_addr 8 with 0xAAAA5555 in the same cycle -> old value returned; refetch -> 0xAAAA5555.
REQ-035 Assert reset_n low with 2 responses pending -> rsp_valid=0 immediately; after release, req_ready=1 after one edge, loaded contents preserved.
REQ-036 With IMEM_PARITY_EN, force a stored parity bit flip at word 5 and fetch pc 0x14 -> DEADBEEF, err 3.
